// File: rtl/branch_redirect_ctrl_pkg.sv
// branch_redirect_ctrl_pkg: shared funct3 codes, defaults and FSM state type for the redirect controller
package branch_redirect_ctrl_pkg;
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int FLUSH_CNT_W = 3;
  typedef enum logic [1:0] {IDLE, FLUSH, PEND} state_t;
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: maps funct3 and comparator flags to branch-taken and illegal-encoding flags
module branch_cond_eval
  import branch_redirect_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       BrLt,
  output logic       cond,
  output logic       illegal
);
  always_comb begin
    illegal = funct3[2:1] == 2'b01;
    cond = funct3 == BR_BEQ ? BrEq :
           funct3 == BR_BNE ? !BrEq :
           (funct3 == BR_BLT || funct3 == BR_BLTU) ? BrLt :
           (funct3 == BR_BGE || funct3 == BR_BGEU) ? !BrLt : 1'b0;
  end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: resolves EX control transfers, owns the fetch PC, flushes and buffers stalled redirects
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        BrEq,
  input  logic        BrLt,
  output logic        BrUn,
  input  logic        stall,
  output logic [31:0] pc_o,
  output logic        flush_o,
  output logic        illegal_br_o,
  output logic        misalign_o,
  output logic [31:0] taken_cnt_o
);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES);
  state_t state, state_nx;
  logic [FLUSH_CNT_W-1:0] fcnt, fcnt_nx;
  logic [31:0] pend_pc, pc_nx, target;
  logic pending, accept, cond, illegal, take, redirect, apply, go;
  assign pending = state == PEND;
  assign flush_o = fcnt != '0;
  assign accept = ex_valid & !flush_o & !pending;
  assign BrUn = accept & ex_is_branch & ex_funct3[1];
  branch_cond_eval u_cond (
    .funct3 (ex_funct3),
    .BrEq   (BrEq),
    .BrLt   (BrLt),
    .cond   (cond),
    .illegal(illegal)
  );
  assign target = ex_is_jalr ? (ex_rs1 + ex_imm) & ~32'h1 : ex_pc + ex_imm;
  assign take = accept & (ex_is_jal | ex_is_jalr | (ex_is_branch & cond));
  // a target with bit1 set is reported, never followed
  assign redirect = take & !target[1];
  assign apply = pending & !stall;
  assign go = apply | (redirect & !stall);
  always_comb begin
    pc_nx = apply ? pend_pc : go ? target : stall ? pc_o : pc_o + 32'd4;
    fcnt_nx = go ? FLUSH_INIT : flush_o ? fcnt - FLUSH_CNT_W'(1) : fcnt;
    state_nx = go ? FLUSH :
               (redirect & stall) ? PEND :
               (state == FLUSH && fcnt_nx == '0) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      fcnt         <= '0;
      pc_o         <= RESET_PC;
      pend_pc      <= '0;
      taken_cnt_o  <= '0;
      illegal_br_o <= 1'b0;
      misalign_o   <= 1'b0;
    end else begin
      state        <= state_nx;
      fcnt         <= fcnt_nx;
      pc_o         <= pc_nx;
      if (redirect & stall) pend_pc <= target;
      taken_cnt_o  <= taken_cnt_o + {31'b0, redirect};
      illegal_br_o <= accept & ex_is_branch & illegal;
      misalign_o   <= take & target[1];
    end
  end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed vectors; stimulus queues expected outputs, a negedge monitor checks them
module tb_branch_redirect_ctrl;
  import branch_redirect_ctrl_pkg::*;
  typedef struct {
    logic v, br, jal, jalr;
    logic [2:0] f3;
    logic [31:0] pc, imm, rs1;
    logic eq, lt;
  } in_t;
  typedef struct {
    string n;
    logic [31:0] pc;
    logic fl;
    logic [31:0] cnt;
    logic il, mis, brun;
  } exp_t;
  logic clk = 0, rst = 1;
  logic ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, BrEq, BrLt, BrUn, stall;
  logic [2:0] ex_funct3;
  logic [31:0] ex_pc, ex_imm, ex_rs1, pc_o, taken_cnt_o;
  logic flush_o, illegal_br_o, misalign_o;
  in_t nx;
  logic nx_stall;
  exp_t sb[$];
  exp_t e;
  int n_vec = 0, n_bad = 0;
  bit bad;
  branch_redirect_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .BrEq(BrEq), .BrLt(BrLt),
    .BrUn(BrUn), .stall(stall), .pc_o(pc_o), .flush_o(flush_o),
    .illegal_br_o(illegal_br_o), .misalign_o(misalign_o), .taken_cnt_o(taken_cnt_o)
  );
  always #5 clk = ~clk;
  function automatic in_t nop();
    in_t r = '{default: '0};
    return r;
  endfunction
  function automatic in_t br(input logic [2:0] f3, input logic [31:0] pc, imm, input logic eq, lt);
    in_t r = '{default: '0};
    r.v = 1; r.br = 1; r.f3 = f3; r.pc = pc; r.imm = imm; r.eq = eq; r.lt = lt;
    return r;
  endfunction
  function automatic in_t jal(input logic [31:0] pc, imm);
    in_t r = '{default: '0};
    r.v = 1; r.jal = 1; r.pc = pc; r.imm = imm;
    return r;
  endfunction
  function automatic in_t jalr(input logic [31:0] rs1, imm);
    in_t r = '{default: '0};
    r.v = 1; r.jalr = 1; r.rs1 = rs1; r.imm = imm;
    return r;
  endfunction
  task automatic push(input string n, input logic [31:0] pc, input logic fl, input logic [31:0] cnt,
                      input logic il, mis, brun);
    exp_t x;
    x.n = n; x.pc = pc; x.fl = fl; x.cnt = cnt; x.il = il; x.mis = mis; x.brun = brun;
    sb.push_back(x);
  endtask
  task automatic vec(input string n, input logic [31:0] pc, input logic fl, input logic [31:0] cnt,
                     input logic il, mis, brun);
    @(posedge clk);
    #1;
    ex_valid = nx.v; ex_is_branch = nx.br; ex_is_jal = nx.jal; ex_is_jalr = nx.jalr;
    ex_funct3 = nx.f3; ex_pc = nx.pc; ex_imm = nx.imm; ex_rs1 = nx.rs1;
    BrEq = nx.eq; BrLt = nx.lt; stall = nx_stall;
    push(n, pc, fl, cnt, il, mis, brun);
  endtask
  task automatic chk(input string n, input string f, input logic [31:0] act, req);
    if (act !== req) begin
      $display("FAIL %s.%s: got %h expected %h", n, f, act, req);
      bad = 1;
    end
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      bad = 0;
      chk(e.n, "pc_o", pc_o, e.pc);
      chk(e.n, "flush_o", {31'b0, flush_o}, {31'b0, e.fl});
      chk(e.n, "taken_cnt_o", taken_cnt_o, e.cnt);
      chk(e.n, "illegal_br_o", {31'b0, illegal_br_o}, {31'b0, e.il});
      chk(e.n, "misalign_o", {31'b0, misalign_o}, {31'b0, e.mis});
      chk(e.n, "BrUn", {31'b0, BrUn}, {31'b0, e.brun});
      if (bad) n_bad++;
    end
  end
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    nx = nop(); nx_stall = 0;
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; ex_funct3 = 0;
    ex_pc = 0; ex_imm = 0; ex_rs1 = 0; BrEq = 0; BrLt = 0; stall = 0;
    vec("reset", 32'h0, 0, 0, 0, 0, 0);
    rst = 0;
    vec("seq4", 32'h4, 0, 0, 0, 0, 0);
    vec("seq8", 32'h8, 0, 0, 0, 0, 0);
    vec("seq12", 32'hC, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1;
    push("async_rst", 32'h0, 0, 0, 0, 0, 0);
    vec("rst_hold", 32'h0, 0, 0, 0, 0, 0);
    rst = 0;
    nx = br(BR_BEQ, 32'h100, 32'h20, 1, 0);
    vec("beq_issue", 32'h4, 0, 0, 0, 0, 0);
    nx = br(BR_BGEU, 32'h500, 32'h10, 0, 0);
    vec("beq_redirect", 32'h120, 1, 1, 0, 0, 0);
    nx = jal(32'h600, 32'h0);
    vec("flush_squash", 32'h124, 1, 1, 0, 0, 0);
    nx = br(BR_BLTU, 32'h700, 32'h40, 0, 0);
    vec("bltu_brun", 32'h128, 0, 1, 0, 0, 1);
    nx = jalr(32'h203, 32'h4);
    vec("bltu_not_taken", 32'h12C, 0, 1, 0, 0, 0);
    nx = jalr(32'h201, 32'h4);
    vec("jalr_misalign", 32'h130, 0, 1, 0, 1, 0);
    nx = nop();
    vec("jalr_redirect", 32'h204, 1, 2, 0, 0, 0);
    vec("jalr_flush", 32'h208, 1, 2, 0, 0, 0);
    nx = jal(32'h3F0, 32'h10); nx_stall = 1;
    vec("stall_issue", 32'h20C, 0, 2, 0, 0, 0);
    vec("stall_capture", 32'h20C, 0, 3, 0, 0, 0);
    vec("stall_hold", 32'h20C, 0, 3, 0, 0, 0);
    nx_stall = 0;
    vec("stall_release", 32'h20C, 0, 3, 0, 0, 0);
    vec("pend_apply", 32'h400, 1, 3, 0, 0, 0);
    nx = nop();
    vec("pend_flush", 32'h404, 1, 3, 0, 0, 0);
    nx = br(3'b010, 32'h900, 32'h8, 1, 1);
    vec("illegal_issue", 32'h408, 0, 3, 0, 0, 1);
    nx = nop();
    vec("illegal_pulse", 32'h40C, 0, 3, 1, 0, 0);
    nx = jal(32'hFFFF_FFF0, 32'hC);
    vec("illegal_clear", 32'h410, 0, 3, 0, 0, 0);
    nx = nop();
    vec("wrap_target", 32'hFFFF_FFFC, 1, 4, 0, 0, 0);
    vec("wrap_pc", 32'h0, 1, 4, 0, 0, 0);
    nx = br(BR_BNE, 32'h10, 32'h30, 0, 0);
    vec("post_wrap", 32'h4, 0, 4, 0, 0, 0);
    nx = nop();
    vec("bne_redirect", 32'h40, 1, 5, 0, 0, 0);
    vec("bne_flush", 32'h44, 1, 5, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      n_bad++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
